jogo_sequencia_param: RTL and testbench

Parametrised sequence-memory game controller, the successor to the fixed 4-button, 16-round game datapath.
- The sequence is built by the player: each round, the player repeats every stored entry, then inserts one new entry.
- New over the previous generation: the stored sequence is replayed on the LEDs before each round, and a multi-button press is rejected as an error.
- Sits between the debounced button inputs and the LED/display outputs of the board top level.

---
 rtl/jogo_sequencia_param_pkg.sv | 25 ++
 rtl/jogo_sequencia_param_detector.sv | 39 +++
 rtl/jogo_sequencia_param.sv | 218 +++++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_sequencia_param_pkg.sv
// Shared definitions for the sequence-memory game: state encoding and the
// one-hot test used on button values.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA_ON   = 4'd2,
    MOSTRA_OFF  = 4'd3,
    ESPERA      = 4'd4,
    COMPARA     = 4'd5,
    PROX_JOGADA = 4'd6,
    ESPERA_NOVA = 4'd7,
    GRAVA       = 4'd8,
    PROX_RODADA = 4'd9,
    FIM_GANHOU  = 4'd10,
    FIM_PERDEU  = 4'd11
  } estado_t;

  // Callers zero-extend narrower button vectors to 8 bits.
  function automatic logic eh_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/jogo_sequencia_param_detector.sv
// Button play detector: registers the debounced buttons once and flags the
// cycle where the registered value leaves all-zero.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                tem_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic                valida
);

  logic [N_BOTOES-1:0] r_botoes;
  logic [N_BOTOES-1:0] r_anterior;
  logic [7:0]          w_estendido;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_botoes   <= '0;
      r_anterior <= '0;
    end else begin
      r_botoes   <= botoes;
      r_anterior <= r_botoes;
    end
  end

  always_comb begin
    w_estendido                 = 8'd0;
    w_estendido[N_BOTOES-1:0]   = r_botoes;
  end

  assign tem_jogada = (r_botoes != '0) && (r_anterior == '0);
  assign jogada     = r_botoes;
  assign valida     = eh_one_hot(w_estendido);

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game controller: the player builds the sequence one entry
// per round, it is replayed on the LEDs, then must be repeated in order.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int PROF      = 16,
  parameter int TIMEOUT   = 5000,
  parameter int TEMPO_LED = 500
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [N_BOTOES-1:0]        botoes,
  output logic [N_BOTOES-1:0]        leds,
  output logic                       pronto,
  output logic                       ganhou,
  output logic                       perdeu,
  output logic [3:0]                 db_estado,
  output logic [$clog2(PROF+1)-1:0]  db_rodada,
  output logic                       db_timeout
);

  localparam int W_A   = $clog2(PROF);
  localparam int W_R   = $clog2(PROF + 1);
  localparam int MAX_C = (TIMEOUT > TEMPO_LED) ? TIMEOUT : TEMPO_LED;
  localparam int W_C   = $clog2(MAX_C + 1);

  localparam logic [W_R-1:0] C_PROF    = W_R'(PROF);
  localparam logic [W_R-1:0] C_UM_R    = W_R'(1);
  localparam logic [W_A-1:0] C_UM_A    = W_A'(1);
  localparam logic [W_C-1:0] C_UM_C    = W_C'(1);
  localparam logic [W_C-1:0] C_TIMEOUT = W_C'(TIMEOUT - 1);
  localparam logic [W_C-1:0] C_LED     = W_C'(TEMPO_LED - 1);

  estado_t             r_estado;
  estado_t             w_prox;
  logic [W_A-1:0]      r_addr;
  logic [W_A-1:0]      w_addr_prox;
  logic [W_R-1:0]      r_rodada;
  logic [W_R-1:0]      w_rodada_prox;
  logic [W_C-1:0]      r_cont;
  logic                w_conta;
  logic                w_expirou;
  logic                w_ultimo;
  logic [N_BOTOES-1:0] r_mem [PROF];
  logic [N_BOTOES-1:0] r_jogada;
  logic                r_valida;
  logic                w_tem;
  logic [N_BOTOES-1:0] w_jogada;
  logic                w_valida;
  logic [N_BOTOES-1:0] r_leds;
  logic                r_pronto;
  logic                r_ganhou;
  logic                r_perdeu;
  logic                r_timeout;

  detector_jogada #(
    .N_BOTOES(N_BOTOES)
  ) u_detector (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .tem_jogada (w_tem),
    .jogada     (w_jogada),
    .valida     (w_valida)
  );

  assign w_ultimo = ({1'b0, r_addr} == (r_rodada - C_UM_R));
  assign w_conta  = (r_estado inside {MOSTRA_ON, MOSTRA_OFF, ESPERA, ESPERA_NOVA})
                    && (w_prox == r_estado);

  always_comb begin
    w_prox        = r_estado;
    w_addr_prox   = r_addr;
    w_rodada_prox = r_rodada;
    w_expirou     = 1'b0;
    case (r_estado)
      INICIAL: begin
        if (iniciar) w_prox = PREPARA;
        else         w_prox = INICIAL;
      end
      PREPARA: begin
        w_rodada_prox = '0;
        w_addr_prox   = '0;
        w_prox        = ESPERA_NOVA;
      end
      MOSTRA_ON: begin
        if (w_tem && !w_valida)   w_prox = FIM_PERDEU;
        else if (r_cont == C_LED) w_prox = MOSTRA_OFF;
        else                      w_prox = MOSTRA_ON;
      end
      MOSTRA_OFF: begin
        if (w_tem && !w_valida) begin
          w_prox = FIM_PERDEU;
        end else if (r_cont == C_LED) begin
          if (w_ultimo) begin
            w_prox      = ESPERA;
            w_addr_prox = '0;
          end else begin
            w_prox      = MOSTRA_ON;
            w_addr_prox = r_addr + C_UM_A;
          end
        end else begin
          w_prox = MOSTRA_OFF;
        end
      end
      ESPERA: begin
        // A play detected on the expiry cycle takes precedence over timeout.
        if (w_tem) begin
          w_prox = COMPARA;
        end else if (r_cont == C_TIMEOUT) begin
          w_prox    = FIM_PERDEU;
          w_expirou = 1'b1;
        end else begin
          w_prox = ESPERA;
        end
      end
      COMPARA: begin
        if (!r_valida || (r_jogada != r_mem[r_addr])) w_prox = FIM_PERDEU;
        else if (!w_ultimo)                           w_prox = PROX_JOGADA;
        else if (r_rodada == C_PROF)                  w_prox = PROX_RODADA;
        else                                          w_prox = ESPERA_NOVA;
      end
      PROX_JOGADA: begin
        w_addr_prox = r_addr + C_UM_A;
        w_prox      = ESPERA;
      end
      ESPERA_NOVA: begin
        if (w_tem) begin
          if (w_valida) w_prox = GRAVA;
          else          w_prox = FIM_PERDEU;
        end else if (r_cont == C_TIMEOUT) begin
          w_prox    = FIM_PERDEU;
          w_expirou = 1'b1;
        end else begin
          w_prox = ESPERA_NOVA;
        end
      end
      GRAVA: begin
        w_prox = PROX_RODADA;
      end
      PROX_RODADA: begin
        w_addr_prox = '0;
        // Only a completed repeat of the full-depth round arrives here at PROF.
        if (r_rodada == C_PROF) begin
          w_prox = FIM_GANHOU;
        end else begin
          w_rodada_prox = r_rodada + C_UM_R;
          w_prox        = MOSTRA_ON;
        end
      end
      FIM_GANHOU, FIM_PERDEU: begin
        if (iniciar) w_prox = PREPARA;
        else         w_prox = r_estado;
      end
      default: begin
        w_prox = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_addr   <= '0;
      r_rodada <= '0;
      r_cont   <= '0;
    end else begin
      r_estado <= w_prox;
      r_addr   <= w_addr_prox;
      r_rodada <= w_rodada_prox;
      if (w_conta) r_cont <= r_cont + C_UM_C;
      else         r_cont <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_jogada <= '0;
      r_valida <= 1'b0;
    end else if (w_tem) begin
      r_jogada <= w_jogada;
      r_valida <= w_valida;
    end
  end

  always_ff @(posedge clock) begin
    if (r_estado == GRAVA) r_mem[r_rodada[W_A-1:0]] <= r_jogada;
  end

  // Outputs are registered from the next state so they line up with db_estado.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_leds    <= '0;
      r_pronto  <= 1'b0;
      r_ganhou  <= 1'b0;
      r_perdeu  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_leds   <= (w_prox == MOSTRA_ON) ? r_mem[w_addr_prox] : '0;
      r_pronto <= (w_prox == FIM_GANHOU) || (w_prox == FIM_PERDEU);
      r_ganhou <= (w_prox == FIM_GANHOU);
      r_perdeu <= (w_prox == FIM_PERDEU);
      if (w_prox == FIM_PERDEU) r_timeout <= (r_estado == FIM_PERDEU) ? r_timeout : w_expirou;
      else                      r_timeout <= 1'b0;
    end
  end

  assign leds       = r_leds;
  assign pronto     = r_pronto;
  assign ganhou     = r_ganhou;
  assign perdeu     = r_perdeu;
  assign db_estado  = r_estado;
  assign db_rodada  = r_rodada;
  assign db_timeout = r_timeout;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param: directed vector table, corner
// sequences, and random games checked against a game-level model.
module tb_jogo_sequencia_param;

  localparam int N_BOTOES  = 4;
  localparam int PROF      = 4;
  localparam int TIMEOUT   = 50;
  localparam int TEMPO_LED = 5;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic [3:0] db_estado;
  logic [2:0] db_rodada;
  logic       db_timeout;

  int checks = 0;
  int errors = 0;
  logic [3:0] cap[$];
  logic [3:0] modelo[$];

  typedef struct packed {
    logic [3:0] espera;
    logic [3:0] botao;
    logic [3:0] est;
    logic [2:0] rod;
  } vec_t;

  vec_t tab [14];

  jogo_sequencia_param #(
    .N_BOTOES(N_BOTOES), .PROF(PROF), .TIMEOUT(TIMEOUT), .TEMPO_LED(TEMPO_LED)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .botoes     (botoes),
    .leds       (leds),
    .pronto     (pronto),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .db_estado  (db_estado),
    .db_rodada  (db_rodada),
    .db_timeout (db_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Waits for a state; replay LED samples are captured on the way.
  task automatic wait_for(input int alvo, input int limite);
    int n = 0;
    while (int'(db_estado) != alvo && n < limite) begin
      if (db_estado == 4'd2 || db_estado == 4'd3) cap.push_back(leds);
      tick();
      n++;
    end
    chk("wait_estado", int'(db_estado), alvo);
  endtask

  task automatic pressiona(input logic [3:0] v);
    botoes = v;
    tick();
    botoes = 4'b0000;
    tick();
    tick();
  endtask

  task automatic iniciar_jogo();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Expected replay: each stored entry lit TEMPO_LED cycles, then dark TEMPO_LED.
  task automatic compara_replay();
    logic [3:0] esp[$];
    int dif = -1;
    foreach (modelo[k]) begin
      for (int t = 0; t < TEMPO_LED; t++) esp.push_back(modelo[k]);
      for (int t = 0; t < TEMPO_LED; t++) esp.push_back(4'b0000);
    end
    checks++;
    if (cap.size() != esp.size()) dif = 0;
    else foreach (esp[k]) if (dif < 0 && cap[k] !== esp[k]) dif = k;
    if (dif >= 0) begin
      errors++;
      $display("FAIL replay: got %0d samples, expected %0d, first difference at sample %0d",
               cap.size(), esp.size(), dif);
    end
  endtask

  function automatic logic [3:0] one_hot(input int k);
    logic [3:0] t = 4'b0001;
    return t << k;
  endfunction

  function automatic logic [3:0] multi();
    logic [3:0] v = 4'($urandom_range(0, 15));
    if ($countones(v) < 2) v = v | 4'b1001;
    return v;
  endfunction

  task automatic jogo_aleatorio();
    int r = 0;
    bit fim = 1'b0;
    bit exp_ganhou = 1'b0;
    bit exp_to = 1'b0;
    int acao;
    logic [3:0] v;
    modelo.delete();
    iniciar_jogo();
    wait_for(7, 50);
    while (!fim) begin
      for (int i = 0; i < r && !fim; i++) begin
        cap.delete();
        wait_for(4, 300);
        if (i == 0) compara_replay();
        acao = $urandom_range(0, 39);
        if (acao == 0) begin
          fim = 1'b1; exp_to = 1'b1;
        end else if (acao == 1) begin
          v = one_hot($urandom_range(0, 3));
          if (v == modelo[i]) v = {v[2:0], v[3]};
          pressiona(v); fim = 1'b1;
        end else if (acao == 2) begin
          pressiona(multi()); fim = 1'b1;
        end else begin
          pressiona(modelo[i]);
        end
      end
      if (!fim) begin
        if (r == PROF) begin
          fim = 1'b1; exp_ganhou = 1'b1;
        end else begin
          wait_for(7, 300);
          acao = $urandom_range(0, 19);
          if (acao == 0) begin
            fim = 1'b1; exp_to = 1'b1;
          end else if (acao == 1) begin
            pressiona(multi()); fim = 1'b1;
          end else begin
            v = one_hot($urandom_range(0, 3));
            pressiona(v);
            modelo.push_back(v);
            r++;
          end
        end
      end
    end
    wait_for(exp_ganhou ? 10 : 11, 300);
    chk("rnd_ganhou",  int'(ganhou), int'(exp_ganhou));
    chk("rnd_perdeu",  int'(perdeu), int'(!exp_ganhou));
    chk("rnd_pronto",  int'(pronto), 1);
    chk("rnd_timeout", int'(db_timeout), int'(exp_to));
    chk("rnd_rodada",  int'(db_rodada), r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab = '{
      '{4'd7, 4'b0001, 4'd9, 3'd0},
      '{4'd4, 4'b0001, 4'd7, 3'd1},
      '{4'd7, 4'b0010, 4'd9, 3'd1},
      '{4'd4, 4'b0001, 4'd6, 3'd2},
      '{4'd4, 4'b0010, 4'd7, 3'd2},
      '{4'd7, 4'b0100, 4'd9, 3'd2},
      '{4'd4, 4'b0001, 4'd6, 3'd3},
      '{4'd4, 4'b0010, 4'd6, 3'd3},
      '{4'd4, 4'b0100, 4'd7, 3'd3},
      '{4'd7, 4'b1000, 4'd9, 3'd3},
      '{4'd4, 4'b0001, 4'd6, 3'd4},
      '{4'd4, 4'b0010, 4'd6, 3'd4},
      '{4'd4, 4'b0100, 4'd6, 3'd4},
      '{4'd4, 4'b1000, 4'd9, 3'd4}
    };
    reset = 1'b1; iniciar = 1'b0; botoes = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_leds",    int'(leds), 0);
    chk("rst_pronto",  int'(pronto), 0);
    chk("rst_ganhou",  int'(ganhou), 0);
    chk("rst_perdeu",  int'(perdeu), 0);
    chk("rst_estado",  int'(db_estado), 0);
    chk("rst_rodada",  int'(db_rodada), 0);
    chk("rst_timeout", int'(db_timeout), 0);

    // Full winning game from the vector table.
    iniciar_jogo();
    chk("ini_estado", int'(db_estado), 1);
    modelo.delete();
    for (int i = 0; i < 14; i++) begin
      cap.delete();
      wait_for(int'(tab[i].espera), 300);
      if (i > 0 && tab[i-1].espera == 4'd7) compara_replay();
      pressiona(tab[i].botao);
      if (tab[i].espera == 4'd7) modelo.push_back(tab[i].botao);
      chk("tab_estado", int'(db_estado), int'(tab[i].est));
      chk("tab_rodada", int'(db_rodada), int'(tab[i].rod));
    end
    tick();
    chk("win_estado", int'(db_estado), 10);
    chk("win_ganhou", int'(ganhou), 1);
    chk("win_pronto", int'(pronto), 1);
    chk("win_perdeu", int'(perdeu), 0);
    chk("win_rodada", int'(db_rodada), 4);

    // Round 2, wrong first repeat: loss three edges after the press.
    iniciar_jogo();
    chk("rei_estado", int'(db_estado), 1);
    chk("rei_ganhou", int'(ganhou), 0);
    chk("rei_pronto", int'(pronto), 0);
    modelo.delete();
    wait_for(7, 50);  pressiona(4'b0001); modelo.push_back(4'b0001);
    wait_for(4, 300); pressiona(4'b0001);
    wait_for(7, 50);  pressiona(4'b0010); modelo.push_back(4'b0010);
    cap.delete();
    wait_for(4, 300);
    compara_replay();
    botoes = 4'b0100; tick();
    chk("err_k1_estado", int'(db_estado), 4);
    botoes = 4'b0000; tick();
    chk("err_k2_estado", int'(db_estado), 5);
    chk("err_k2_perdeu", int'(perdeu), 0);
    tick();
    chk("err_k3_estado",  int'(db_estado), 11);
    chk("err_k3_perdeu",  int'(perdeu), 1);
    chk("err_k3_pronto",  int'(pronto), 1);
    chk("err_k3_timeout", int'(db_timeout), 0);
    iniciar_jogo();
    chk("restart_estado", int'(db_estado), 1);
    chk("restart_perdeu", int'(perdeu), 0);
    chk("restart_pronto", int'(pronto), 0);
    tick();
    chk("restart_estado2", int'(db_estado), 7);

    // Timeout in ESPERA: exactly TIMEOUT cycles in the wait state.
    pressiona(4'b0010);
    wait_for(4, 300);
    repeat (TIMEOUT - 1) tick();
    chk("to_ainda_espera", int'(db_estado), 4);
    tick();
    chk("to_estado",  int'(db_estado), 11);
    chk("to_perdeu",  int'(perdeu), 1);
    chk("to_timeout", int'(db_timeout), 1);
    iniciar_jogo();
    chk("to_limpo", int'(db_timeout), 0);

    // Multi-button insertion.
    wait_for(7, 50);
    pressiona(4'b0011);
    chk("multi_estado",  int'(db_estado), 11);
    chk("multi_perdeu",  int'(perdeu), 1);
    chk("multi_timeout", int'(db_timeout), 0);

    // Play detected on the same cycle the timeout would expire.
    iniciar_jogo();
    wait_for(7, 50);
    pressiona(4'b0100);
    wait_for(4, 300);
    repeat (TIMEOUT - 2) tick();
    botoes = 4'b0100; tick();
    chk("sim_estado_k1", int'(db_estado), 4);
    botoes = 4'b0000; tick();
    chk("sim_estado_k2", int'(db_estado), 5);
    chk("sim_timeout",   int'(db_timeout), 0);
    tick();
    chk("sim_estado_k3", int'(db_estado), 7);

    // Asynchronous reset in the middle of a replay.
    pressiona(4'b1000);
    wait_for(2, 50);
    tick(); tick();
    chk("mostra_leds", int'(leds), 4);
    reset = 1'b1;
    #1;
    chk("arst_estado", int'(db_estado), 0);
    chk("arst_leds",   int'(leds), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_hold", int'(db_estado), 0);

    for (int g = 0; g < 30; g++) jogo_aleatorio();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
